// File: rtl/fir_pkg.sv
// Shared widths, FSM state type and accumulator scaling for the FIR tap sequencer.
// Optional macro FIR_ROUND_EN: round half up before scaling instead of truncating.
package fir_pkg;

  localparam int unsigned NTAPS_DEF   = 16;
  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned ACCW_DEF    = 33;
  localparam int unsigned MAC_LAT_DEF = 1;
  localparam int unsigned SAT_W       = ACCW_DEF + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT, OUT} fir_state_t;
  typedef logic signed [DW_DEF-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(DW_DEF-1){1'b1}}});
  localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(DW_DEF-1){1'b0}}});

  // Scale a Q2.30-style accumulator back to Q1.15 with saturation.
  function automatic sample_t sat_shift(input logic signed [ACCW_DEF-1:0] acc);
    logic signed [SAT_W-1:0] wide;
    wide = SAT_W'(acc);
`ifdef FIR_ROUND_EN
    wide = wide + $signed(SAT_W'(1) << (DW_DEF - 2));
`endif
    wide = wide >>> (DW_DEF - 1);
    if (wide > SAT_W'(SAMPLE_MAX)) return SAMPLE_MAX;
    if (wide < SAT_W'(SAMPLE_MIN)) return SAMPLE_MIN;
    return sample_t'(wide);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample delay line: one write port advancing wr_ptr, one indexed read.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = NTAPS_DEF,
  parameter int unsigned W     = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [W-1:0]             rd_data_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];

  // Store the new sample at the write pointer and advance it (wraps naturally).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + PW'(1);
    end
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: buffers samples/coefficients and steps an external MAC
// through all taps, then saturates the accumulator into one filtered sample.
// Optional macro FIR_ROUND_EN selects rounding in the final scaling.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS   = NTAPS_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned ACCW    = ACCW_DEF,
  parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  input  logic [DW-1:0]            sample_i,
  output logic                     sample_ready_o,
  input  logic                     coef_we_i,
  input  logic [$clog2(NTAPS)-1:0] coef_addr_i,
  input  logic [DW-1:0]            coef_data_i,
  output logic                     mac_clk_en_o,
  output logic                     mac_rst_o,
  output logic [DW-1:0]            mac_a_o,
  output logic [DW-1:0]            mac_b_o,
  input  logic [ACCW-1:0]          mac_result_i,
  output logic                     filt_valid_o,
  output logic [DW-1:0]            filt_o,
  output logic                     overrun_o
);

  localparam int unsigned TW  = $clog2(NTAPS);
  localparam int unsigned WCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  fir_state_t     state_q, state_d;
  logic [TW-1:0]  k_q, k_d;
  logic [TW-1:0]  base_q, base_d;
  logic [TW-1:0]  rd_idx, wr_ptr;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0]  coef_q [NTAPS];
  logic [DW-1:0]  tap_data_c;
  logic           accept, coef_wr;
  logic           ready_d, mac_rst_d, mac_en_d;
  logic [DW-1:0]  mac_a_d, mac_b_d;

  fir_delay_line #(.DEPTH(NTAPS), .W(DW)) u_delay (
    .clk      (clk_i),
    .rst      (rst_i),
    .we       (accept),
    .wr_data  (sample_i),
    .rd_idx   (rd_idx),
    .wr_ptr   (wr_ptr),
    .rd_data_c(tap_data_c)
  );

  // Next state, tap/wait counters and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    coef_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        coef_wr = coef_we_i;
        if (sample_valid_i) begin
          accept  = 1'b1;
          base_d  = wr_ptr;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        if (k_q == TW'(NTAPS - 1)) begin
          wcnt_d  = '0;
          state_d = WAIT;
        end else begin
          k_d = k_q + TW'(1);
        end
      end
      WAIT: begin
        if (wcnt_q == WCW'(MAC_LAT - 1)) state_d = OUT;
        else wcnt_d = wcnt_q + WCW'(1);
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Newest sample sits at base; older taps walk backwards around the ring.
    rd_idx    = base_q - k_d;
    ready_d   = (state_d == IDLE);
    mac_rst_d = (state_d == CLEAR);
    mac_en_d  = (state_d == RUN);
    mac_a_d   = mac_en_d ? tap_data_c : '0;
    mac_b_d   = mac_en_d ? coef_q[k_d] : '0;
  end

  // FSM state and sequencing counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Coefficient bank; writes only land while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  // Registered MAC drive, result capture and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_ready_o <= 1'b1;
      mac_clk_en_o   <= 1'b0;
      mac_rst_o      <= 1'b0;
      mac_a_o        <= '0;
      mac_b_o        <= '0;
      filt_valid_o   <= 1'b0;
      filt_o         <= '0;
      overrun_o      <= 1'b0;
    end else begin
      sample_ready_o <= ready_d;
      mac_clk_en_o   <= mac_en_d;
      mac_rst_o      <= mac_rst_d;
      mac_a_o        <= mac_a_d;
      mac_b_o        <= mac_b_d;
      filt_valid_o   <= (state_q == OUT);
      if (state_q == OUT) filt_o <= sat_shift(mac_result_i);
      if (sample_valid_i && (state_q != IDLE)) overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural MAC and a reference FIR model.
module tb_fir_tap_sequencer;

  localparam int NT = 16;
`ifdef FIR_ROUND_EN
  localparam logic [15:0] DELAY_EXP = 16'h1000;
`else
  localparam logic [15:0] DELAY_EXP = 16'h0FFF;
`endif

  logic        clk = 1'b0;
  logic        rst, sample_valid, coef_we;
  logic [15:0] sample, coef_data;
  logic [3:0]  coef_addr;
  logic        sample_ready, mac_clk_en, mac_rst, filt_valid, overrun;
  logic [15:0] mac_a, mac_b, filt;
  logic [32:0] mac_result = '0;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sample_valid_i(sample_valid),
    .sample_i      (sample),
    .sample_ready_o(sample_ready),
    .coef_we_i     (coef_we),
    .coef_addr_i   (coef_addr),
    .coef_data_i   (coef_data),
    .mac_clk_en_o  (mac_clk_en),
    .mac_rst_o     (mac_rst),
    .mac_a_o       (mac_a),
    .mac_b_o       (mac_b),
    .mac_result_i  (mac_result),
    .filt_valid_o  (filt_valid),
    .filt_o        (filt),
    .overrun_o     (overrun)
  );

  // Behavioural MAC: accumulate on enabled edges, result registered one cycle later.
  logic signed [32:0] acc = '0;
  logic signed [31:0] prod;
  always_comb prod = $signed(mac_a) * $signed(mac_b);
  always @(posedge clk) begin
    if (mac_rst) acc <= '0;
    else if (mac_clk_en) acc <= acc + 33'(prod);
    mac_result <= acc;
  end

  // Reference state and scoreboard.
  logic signed [15:0] m_delay [NT];
  logic signed [15:0] m_coef  [NT];
  int                 m_wp;
  logic [15:0]        exp_q [$];
  int                 n_cmp = 0;
  int                 n_err = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_out(input int base);
    longint             sum;
    logic signed [32:0] a33;
    longint             v;
    sum = 0;
    for (int k = 0; k < NT; k++)
      sum += longint'(m_delay[(base - k + NT) % NT]) * longint'(m_coef[k]);
    a33 = 33'(sum);
    v   = longint'(a33);
`ifdef FIR_ROUND_EN
    v = v + 64'sd16384;
`endif
    v = v >>> 15;
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NT; i++) begin
      m_delay[i] = '0;
      m_coef[i]  = '0;
    end
    m_wp = 0;
    exp_q.delete();
  endtask

  task automatic wcoef(input logic [3:0] addr, input logic [15:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    tick();
    coef_we      = 1'b0;
    m_coef[addr] = data;
  endtask

  task automatic send(input logic [15:0] s, input bit with_coef,
                      input logic [3:0] ca, input logic [15:0] cd);
    check("ready before send", 64'(sample_ready), 64'(1));
    sample_valid = 1'b1;
    sample       = s;
    coef_we      = with_coef;
    coef_addr    = ca;
    coef_data    = cd;
    if (with_coef) m_coef[ca] = cd;
    m_delay[m_wp] = s;
    exp_q.push_back(ref_out(m_wp));
    m_wp = (m_wp + 1) % NT;
    tick();
    sample_valid = 1'b0;
    coef_we      = 1'b0;
  endtask

  // Wait for the filtered strobe; elapsed = cycles already spent since acceptance.
  task automatic collect(input string tag, input int elapsed, output logic [15:0] got_val);
    int          cyc;
    int          n_en;
    int          n_clr;
    bit          got;
    logic [15:0] exp;
    cyc = elapsed; n_en = 0; n_clr = 0; got = 1'b0; got_val = '0;
    while (!got && cyc < 40) begin
      if (mac_clk_en) n_en++;
      if (mac_rst) n_clr++;
      tick();
      cyc++;
      if (filt_valid) got = 1'b1;
    end
    check({tag, " latency"}, 64'(cyc), 64'(19));
    if (elapsed == 0) begin
      check({tag, " mac enables"}, 64'(n_en), 64'(16));
      check({tag, " mac clears"}, 64'(n_clr), 64'(1));
    end
    if (got) begin
      got_val = filt;
      check({tag, " queued"}, 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check(tag, 64'(filt), 64'(exp));
      end
      tick();
      check({tag, " strobe width"}, 64'(filt_valid), 64'(0));
      check({tag, " ready after"}, 64'(sample_ready), 64'(1));
      check({tag, " a idle"}, 64'(mac_a), 64'(0));
      check({tag, " b idle"}, 64'(mac_b), 64'(0));
    end
  endtask

  logic [15:0] v;
  int          nv;

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick();
    do_reset();

    // Reset state.
    check("rst filt_valid", 64'(filt_valid), 64'(0));
    check("rst filt", 64'(filt), 64'(0));
    check("rst overrun", 64'(overrun), 64'(0));
    check("rst ready", 64'(sample_ready), 64'(1));
    check("rst mac_clk_en", 64'(mac_clk_en), 64'(0));
    check("rst mac_rst", 64'(mac_rst), 64'(0));
    check("rst mac_a", 64'(mac_a), 64'(0));
    check("rst mac_b", 64'(mac_b), 64'(0));

    // Impulse response.
    wcoef(4'd0, 16'h4000);
    send(16'h2000, 1'b0, 4'd0, 16'h0);
    collect("impulse", 0, v);
    check("impulse value", 64'(v), 64'(16'h1000));

    // Coefficient written in the same idle cycle as the sample.
    do_reset();
    send(16'h2000, 1'b1, 4'd0, 16'h4000);
    collect("same-cycle coef", 0, v);
    check("same-cycle coef value", 64'(v), 64'(16'h1000));

    // Delay-line walk through tap 3.
    do_reset();
    wcoef(4'd3, 16'h7FFF);
    send(16'h1000, 1'b0, 4'd0, 16'h0); collect("delay out1", 0, v);
    check("delay out1 value", 64'(v), 64'(0));
    send(16'h0000, 1'b0, 4'd0, 16'h0); collect("delay out2", 0, v);
    check("delay out2 value", 64'(v), 64'(0));
    send(16'h0000, 1'b0, 4'd0, 16'h0); collect("delay out3", 0, v);
    check("delay out3 value", 64'(v), 64'(0));
    send(16'h0000, 1'b0, 4'd0, 16'h0); collect("delay out4", 0, v);
    check("delay out4 value", 64'(v), 64'(DELAY_EXP));

    // Saturation, both rails.
    do_reset();
    for (int i = 0; i < 4; i++) wcoef(4'(i), 16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      send(16'h7FFF, 1'b0, 4'd0, 16'h0);
      collect("sat pos", 0, v);
    end
    check("sat pos final", 64'(v), 64'(16'h7FFF));
    for (int i = 0; i < 4; i++) begin
      send(16'h8000, 1'b0, 4'd0, 16'h0);
      collect("sat neg", 0, v);
    end
    check("sat neg final", 64'(v), 64'(16'h8000));

    // Overrun: sample and coefficient write during RUN are both dropped.
    do_reset();
    wcoef(4'd0, 16'h4000);
    wcoef(4'd1, 16'h2000);
    send(16'h2000, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 4; i++) tick();
    sample_valid = 1'b1; sample = 16'h7FFF;
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'h7FFF;
    tick();
    sample_valid = 1'b0; coef_we = 1'b0;
    check("overrun set", 64'(overrun), 64'(1));
    collect("overrun inflight", 5, v);
    check("overrun inflight value", 64'(v), 64'(16'h1000));
    check("overrun sticky", 64'(overrun), 64'(1));
    send(16'h1000, 1'b0, 4'd0, 16'h0);
    collect("after overrun", 0, v);
    check("after overrun value", 64'(v), 64'(16'h1000));
    check("overrun still set", 64'(overrun), 64'(1));

    // Reset mid-RUN aborts the computation.
    do_reset();
    check("overrun cleared", 64'(overrun), 64'(0));
    wcoef(4'd0, 16'h4000);
    send(16'h2000, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 7; i++) tick();
    check("pre-abort running", 64'(mac_clk_en), 64'(1));
    do_reset();
    check("abort ready", 64'(sample_ready), 64'(1));
    check("abort mac_clk_en", 64'(mac_clk_en), 64'(0));
    check("abort mac_rst", 64'(mac_rst), 64'(0));
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      if (filt_valid) nv++;
      tick();
    end
    check("abort no filt_valid", 64'(nv), 64'(0));
    wcoef(4'd0, 16'h4000);
    send(16'h2000, 1'b0, 4'd0, 16'h0);
    collect("post-abort impulse", 0, v);
    check("post-abort impulse value", 64'(v), 64'(16'h1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Control and data-feed stage directly upstream of the 16-bit MAC (fakeMac16) in the audio filtering path.
- Accepts one Q1.15 audio sample per request and stores it in an NTAPS-deep circular delay line alongside an NTAPS-entry coefficient bank.
- Steps the MAC through all tap products, then scales and saturates the 33-bit accumulator into a 16-bit filtered sample.

Parameters:
- NTAPS, 16, number of filter taps (power of two, 2..64).
- DW, 16, sample/coefficient width (signed Q1.15).
- ACCW, 33, MAC accumulator width.
- MAC_LAT, 1, cycles from the last enabled MAC edge to a valid result_o.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- sample_valid_i  in  1  new input sample strobe.
- sample_i  in  DW  signed input sample.
- sample_ready_o  out  1  high when in IDLE.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  log2(NTAPS)  coefficient index k.
- coef_data_i  in  DW  signed coefficient h[k].
- mac_clk_en_o  out  1  drives MAC clk_en_i.
- mac_rst_o  out  1  drives MAC rst_i (clears accumulator).
- mac_a_o  out  DW  drives MAC data_a_i (sample x[n-k]).
- mac_b_o  out  DW  drives MAC data_b_i (coefficient h[k]).
- mac_result_i  in  ACCW  from MAC result_o.
- filt_valid_o  out  1  one-cycle output strobe.
- filt_o  out  DW  filtered sample.
- overrun_o  out  1  sticky dropped-sample flag.

Behaviour:
- **Clock and reset:** one clock, clk_i. Reset rst_i is synchronous and active-high.
- **MAC contract:**
  - The MAC accumulates signed a*b into result on each clk_i edge with clk_en_i=1.
  - rst_i=1 clears the accumulator at the edge.
  - result_o is valid MAC_LAT cycles after the last enabled edge.
- **Reset values:**
  - All outputs 0 except sample_ready_o=1.
  - Delay line and coefficient bank cleared to 0.
  - wr_ptr=0, state IDLE.
- **FSM:**
  - IDLE:
    - sample_valid_i=1 writes sample_i to delay[wr_ptr], latches base=wr_ptr, increments wr_ptr modulo NTAPS, and moves to CLEAR.
    - coef_we_i is honoured only in IDLE; it is ignored in all other states.
  - CLEAR: 1 cycle, mac_rst_o=1, tap counter k=0, then RUN.
  - RUN: NTAPS cycles.
    - mac_clk_en_o=1, mac_a_o=delay[(base-k) mod NTAPS], mac_b_o=coef[k], k increments each cycle.
    - Moves to WAIT after k=NTAPS-1.
  - WAIT: MAC_LAT cycles, mac_clk_en_o=0, then OUT.
  - OUT: 1 cycle.
    - Registers filt_o=sat(mac_result_i >>> 15).
    - filt_valid_o=1 in the following cycle.
    - Returns to IDLE.
- **Latency:** filt_valid_o is high exactly NTAPS+MAC_LAT+2 cycles after the accepting edge. Default = 19 cycles.
- **Arithmetic:**
  - Arithmetic right shift by DW-1.
  - Saturation clamps to [0x8000, 0x7FFF].
  - Outside RUN, mac_a_o/mac_b_o are held at 0.
- **Boundaries:**
  - Pointer wrap: (base-k) wraps modulo NTAPS.
  - Overrun: sample_valid_i outside IDLE drops the sample and sets overrun_o. overrun_o is cleared only by rst_i.
  - sample_valid_i and coef_we_i together in IDLE: both take effect, and the coefficient is written before RUN.
  - rst_i in any state: aborts to IDLE next cycle. No filt_valid_o, mac_rst_o=0, mac_clk_en_o=0.

Optional Feature:
- FIR_ROUND_EN defined: adds 2^(DW-2) to mac_result_i before the shift (round half up), with saturation applied afterwards.
- FIR_ROUND_EN undefined: truncates.

Decomposition:
- fir_pkg holds:
  - NTAPS/DW/ACCW defaults.
  - typedef enum fir_state_t {IDLE, CLEAR, RUN, WAIT, OUT}.
  - typedef logic signed [DW-1:0] sample_t.
  - function sat_shift(acc) returning sample_t.
- Sub-module fir_delay_line: circular buffer with write port, wr_ptr and indexed read.

Test Plan:
1. Reset → filt_valid_o=0, filt_o=0, overrun_o=0, sample_ready_o=1, mac_* =0.
2. Impulse: coef[0]=0x4000, others 0; sample 0x2000 → filt_valid_o at cycle +19, filt_o=0x1000.
3. Delay line: coef[3]=0x7FFF, others 0; samples 0x1000,0,0,0 → 4th output 0x0FFF, or 0x1000 with FIR_ROUND_EN. Outputs 1-3 are 0.
4. Saturation: coef[0..3]=0x7FFF; four samples 0x7FFF → final output 0x7FFF. Repeat with four samples 0x8000 → 0x8000.
5. Overrun: sample_valid_i pulsed 5 cycles after acceptance → overrun_o=1 and stays set; the in-flight output is unchanged; next accepted sample filters normally.
6. Reset mid-RUN: rst_i at cycle 8 → no filt_valid_o, sample_ready_o=1 next cycle, then impulse test 2 reproduces 0x1000 after coefficients are reloaded.
